tx_initiated_point_test_initiator: RTL and testbench

TX_INITIATED_POINT_TEST_INITIATOR -- requirements
Module: tx_initiated_point_test_initiator

---
 rtl/tx_initiated_point_test_initiator.sv | 234 +++++++++++++++++++++++
 tb/tb_tx_initiated_point_test_initiator.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_initiated_point_test_initiator.sv
// Transmitter-initiated point test initiator: runs the sideband start/clear/result/end
// exchange around one mainband LFSR burst and captures the partner's comparison results.
module tx_initiated_point_test_initiator #(
    parameter int SB_MSG_WIDTH   = 4,
    parameter int TIMEOUT_CYCLES = 8000
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_tx_d2c_pt_en,
    input  logic                    i_datavref_or_valvref,
    input  logic [1:0]              i_clock_phase,
    input  logic                    i_burst_count,
    input  logic                    i_comparison_mode,
    input  logic                    i_pattern_finished,
    input  logic                    i_SB_Busy,
    input  logic                    i_rx_msg_valid,
    input  logic [SB_MSG_WIDTH-1:0] i_decoded_SB_msg,
    input  logic [15:0]             i_rx_data_bus,
    output logic [SB_MSG_WIDTH-1:0] o_encoded_SB_msg,
    output logic                    o_tx_msg_valid,
    output logic                    o_tx_data_valid,
    output logic [15:0]             o_tx_data_bus,
    output logic [1:0]              o_mainband_pattern_generator_cw,
    output logic                    o_val_pattern_en,
    output logic [15:0]             o_comparison_result,
    output logic                    o_tx_d2c_pt_done,
    output logic                    o_timeout_err
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [SB_MSG_WIDTH-1:0] MSG_NONE        = SB_MSG_WIDTH'(0);
    localparam logic [SB_MSG_WIDTH-1:0] MSG_START_REQ   = SB_MSG_WIDTH'(1);
    localparam logic [SB_MSG_WIDTH-1:0] MSG_START_RESP  = SB_MSG_WIDTH'(2);
    localparam logic [SB_MSG_WIDTH-1:0] MSG_CLR_REQ     = SB_MSG_WIDTH'(3);
    localparam logic [SB_MSG_WIDTH-1:0] MSG_CLR_RESP    = SB_MSG_WIDTH'(4);
    localparam logic [SB_MSG_WIDTH-1:0] MSG_RESULT_REQ  = SB_MSG_WIDTH'(5);
    localparam logic [SB_MSG_WIDTH-1:0] MSG_RESULT_RESP = SB_MSG_WIDTH'(6);
    localparam logic [SB_MSG_WIDTH-1:0] MSG_END_REQ     = SB_MSG_WIDTH'(7);
    localparam logic [SB_MSG_WIDTH-1:0] MSG_END_RESP    = SB_MSG_WIDTH'(8);

    localparam logic [1:0] CW_IDLE      = 2'b00;
    localparam logic [1:0] CW_CLEAR_LFSR = 2'b01;
    localparam logic [1:0] CW_LFSR      = 2'b10;

    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_START_REQ   = 4'd1,
        ST_WAIT_START  = 4'd2,
        ST_CLR_REQ     = 4'd3,
        ST_WAIT_CLR    = 4'd4,
        ST_PAT_CLR     = 4'd5,
        ST_PAT_RUN     = 4'd6,
        ST_RESULT_REQ  = 4'd7,
        ST_WAIT_RESULT = 4'd8,
        ST_END_REQ     = 4'd9,
        ST_WAIT_END    = 4'd10,
        ST_DONE        = 4'd11,
        ST_ERR         = 4'd12
    } state_t;

    state_t                    state_q;
    state_t                    state_d;
    logic                      busy_q;
    logic                      busy_fall;
    logic [CNT_W-1:0]          timer_q;
    logic                      timeout_hit;
    logic [SB_MSG_WIDTH-1:0]   exp_resp;
    logic                      resp_hit;
    logic                      wait_entry;
    logic                      start_entry;
    logic [15:0]               tx_data_q;
    logic [15:0]               result_q;

    logic [SB_MSG_WIDTH-1:0]   enc_msg;
    logic                      tx_msg_valid;
    logic                      tx_data_valid;
    logic [1:0]                pat_cw;
    logic                      val_pat_en;
    logic                      pt_done;
    logic                      timeout_err;

    function automatic logic is_wait(input state_t s);
        return (s == ST_WAIT_START) || (s == ST_WAIT_CLR) ||
               (s == ST_WAIT_RESULT) || (s == ST_WAIT_END);
    endfunction

    // Request handshake: a *_REQ state holds valid with its code until the sideband
    // signals acceptance by a busy high->low transition; only then does the FSM move on.
    assign busy_fall   = busy_q & ~i_SB_Busy;
    assign timeout_hit = (timer_q == CNT_LIMIT);
    assign resp_hit    = i_rx_msg_valid && (i_decoded_SB_msg == exp_resp);
    assign wait_entry  = is_wait(state_d) && (state_d != state_q);
    assign start_entry = (state_d == ST_START_REQ) && (state_q != ST_START_REQ);

    always_comb begin
        exp_resp = MSG_NONE;
        case (state_q)
            ST_WAIT_START:  exp_resp = MSG_START_RESP;
            ST_WAIT_CLR:    exp_resp = MSG_CLR_RESP;
            ST_WAIT_RESULT: exp_resp = MSG_RESULT_RESP;
            ST_WAIT_END:    exp_resp = MSG_END_RESP;
            default:        exp_resp = MSG_NONE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= i_SB_Busy;
        end
    end

    // Disable wins over everything; a matching response wins over the timeout.
    always_comb begin
        state_d = state_q;
        if (!i_tx_d2c_pt_en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:        state_d = ST_START_REQ;
                ST_START_REQ:   if (busy_fall) state_d = ST_WAIT_START;
                ST_WAIT_START: begin
                    if (resp_hit)         state_d = ST_CLR_REQ;
                    else if (timeout_hit) state_d = ST_ERR;
                end
                ST_CLR_REQ:     if (busy_fall) state_d = ST_WAIT_CLR;
                ST_WAIT_CLR: begin
                    if (resp_hit)         state_d = ST_PAT_CLR;
                    else if (timeout_hit) state_d = ST_ERR;
                end
                ST_PAT_CLR:     state_d = ST_PAT_RUN;
                ST_PAT_RUN:     if (i_pattern_finished) state_d = ST_RESULT_REQ;
                ST_RESULT_REQ:  if (busy_fall) state_d = ST_WAIT_RESULT;
                ST_WAIT_RESULT: begin
                    if (resp_hit)         state_d = ST_END_REQ;
                    else if (timeout_hit) state_d = ST_ERR;
                end
                ST_END_REQ:     if (busy_fall) state_d = ST_WAIT_END;
                ST_WAIT_END: begin
                    if (resp_hit)         state_d = ST_DONE;
                    else if (timeout_hit) state_d = ST_ERR;
                end
                ST_DONE:        state_d = ST_DONE;
                ST_ERR:         state_d = ST_ERR;
                default:        state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        enc_msg       = MSG_NONE;
        tx_msg_valid  = 1'b0;
        tx_data_valid = 1'b0;
        pat_cw        = CW_IDLE;
        val_pat_en    = 1'b0;
        pt_done       = 1'b0;
        timeout_err   = 1'b0;
        case (state_q)
            ST_START_REQ: begin
                enc_msg       = MSG_START_REQ;
                tx_msg_valid  = 1'b1;
                tx_data_valid = 1'b1;
            end
            ST_CLR_REQ: begin
                enc_msg      = MSG_CLR_REQ;
                tx_msg_valid = 1'b1;
            end
            ST_RESULT_REQ: begin
                enc_msg      = MSG_RESULT_REQ;
                tx_msg_valid = 1'b1;
            end
            ST_END_REQ: begin
                enc_msg      = MSG_END_REQ;
                tx_msg_valid = 1'b1;
            end
            ST_PAT_CLR: begin
                pat_cw     = CW_CLEAR_LFSR;
                val_pat_en = i_datavref_or_valvref;
            end
            ST_PAT_RUN: begin
                pat_cw     = CW_LFSR;
                val_pat_en = i_datavref_or_valvref;
            end
            ST_DONE: pt_done     = 1'b1;
            ST_ERR:  timeout_err = 1'b1;
            default: ;
        endcase
    end

    // Saturating at the limit keeps the compare stable even if the state lingers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            timer_q <= '0;
        end else if (wait_entry) begin
            timer_q <= '0;
        end else if (is_wait(state_q) && !timeout_hit) begin
            timer_q <= timer_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tx_data_q <= '0;
        end else if (start_entry) begin
            tx_data_q <= {11'b0, i_comparison_mode, i_burst_count, i_clock_phase, 1'b0};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            result_q <= '0;
        end else if (start_entry) begin
            result_q <= '0;
        end else if ((state_q == ST_WAIT_RESULT) && i_tx_d2c_pt_en && resp_hit) begin
            result_q <= i_rx_data_bus;
        end
    end

    assign o_encoded_SB_msg                = enc_msg;
    assign o_tx_msg_valid                  = tx_msg_valid;
    assign o_tx_data_valid                 = tx_data_valid;
    assign o_tx_data_bus                   = tx_data_q;
    assign o_mainband_pattern_generator_cw = pat_cw;
    assign o_val_pattern_en                = val_pat_en;
    assign o_comparison_result             = result_q;
    assign o_tx_d2c_pt_done                = pt_done;
    assign o_timeout_err                   = timeout_err;

endmodule

// File: tb/tb_tx_initiated_point_test_initiator.sv
// Bench for the point test initiator: parameter-encoding table, directed protocol
// scenarios and randomized full flows predicted from the handshake rules.
module tb_tx_initiated_point_test_initiator;

    localparam int MW = 4;
    localparam int TO = 16;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_tx_d2c_pt_en;
    logic          i_datavref_or_valvref;
    logic [1:0]    i_clock_phase;
    logic          i_burst_count;
    logic          i_comparison_mode;
    logic          i_pattern_finished;
    logic          i_SB_Busy;
    logic          i_rx_msg_valid;
    logic [MW-1:0] i_decoded_SB_msg;
    logic [15:0]   i_rx_data_bus;
    logic [MW-1:0] o_encoded_SB_msg;
    logic          o_tx_msg_valid;
    logic          o_tx_data_valid;
    logic [15:0]   o_tx_data_bus;
    logic [1:0]    o_mainband_pattern_generator_cw;
    logic          o_val_pattern_en;
    logic [15:0]   o_comparison_result;
    logic          o_tx_d2c_pt_done;
    logic          o_timeout_err;

    int            n_vec = 0;
    int            n_err = 0;
    logic [3:0]    exp_q[$];
    logic [15:0]   exp_result;

    typedef struct {
        logic [1:0]  phase;
        logic        burst;
        logic        mode;
        logic [15:0] exp_bus;
    } vec_t;

    typedef struct {
        logic [1:0]       phase;
        logic             burst;
        logic             mode;
        logic             vref;
        logic [15:0]      data;
        logic [3:0][1:0]  pre_busy;
        logic [3:0][5:0]  busy_len;
        logic [3:0][4:0]  resp_dly;
        logic [3:0][1:0]  junk;
        logic [7:0]       pat_len;
        logic             abort_pat;
        logic             rst_in_result;
    } flow_cfg_t;

    tx_initiated_point_test_initiator #(
        .SB_MSG_WIDTH  (MW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk                          (i_clk),
        .i_rst                          (i_rst),
        .i_tx_d2c_pt_en                 (i_tx_d2c_pt_en),
        .i_datavref_or_valvref          (i_datavref_or_valvref),
        .i_clock_phase                  (i_clock_phase),
        .i_burst_count                  (i_burst_count),
        .i_comparison_mode              (i_comparison_mode),
        .i_pattern_finished             (i_pattern_finished),
        .i_SB_Busy                      (i_SB_Busy),
        .i_rx_msg_valid                 (i_rx_msg_valid),
        .i_decoded_SB_msg               (i_decoded_SB_msg),
        .i_rx_data_bus                  (i_rx_data_bus),
        .o_encoded_SB_msg               (o_encoded_SB_msg),
        .o_tx_msg_valid                 (o_tx_msg_valid),
        .o_tx_data_valid                (o_tx_data_valid),
        .o_tx_data_bus                  (o_tx_data_bus),
        .o_mainband_pattern_generator_cw(o_mainband_pattern_generator_cw),
        .o_val_pattern_en               (o_val_pattern_en),
        .o_comparison_result            (o_comparison_result),
        .o_tx_d2c_pt_done               (o_tx_d2c_pt_done),
        .o_timeout_err                  (o_timeout_err)
    );

    // Clock and watchdog
    always #5 i_clk = ~i_clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Packed view: {msg_valid, code, data_valid, cw, val_en, done, err}
    task automatic chk_o(input string nm, input logic ev, input logic [3:0] ec, input logic edv,
                         input logic [1:0] ecw, input logic eve, input logic edn, input logic eer);
        logic [10:0] a;
        logic [10:0] e;
        a = {o_tx_msg_valid, o_encoded_SB_msg, o_tx_data_valid, o_mainband_pattern_generator_cw,
             o_val_pattern_en, o_tx_d2c_pt_done, o_timeout_err};
        e = {ev, ec, edv, ecw, eve, edn, eer};
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: outputs got %03h want %03h at %0t", nm, a, e, $time);
        end
    endtask

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %04h want %04h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic quiet(input string nm);
        chk_o(nm, 1'b0, 4'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drive_junk(input logic [1:0] mode, input int k, input logic [3:0] want);
        logic [3:0] jc;
        i_rx_msg_valid   = 1'b0;
        i_decoded_SB_msg = 4'd0;
        i_rx_data_bus    = 16'($urandom);
        if (mode == 2'd1 && $urandom_range(0, 2) == 0) begin
            do jc = 4'($urandom_range(0, 15)); while (jc == want);
            i_rx_msg_valid   = 1'b1;
            i_decoded_SB_msg = jc;
        end else if (mode == 2'd2 && k == 0) begin
            i_rx_msg_valid   = 1'b1;
            i_decoded_SB_msg = 4'd6;
            i_rx_data_bus    = 16'hDEAD;
        end
    endtask

    task automatic clear_rx();
        i_rx_msg_valid   = 1'b0;
        i_decoded_SB_msg = 4'd0;
    endtask

    function automatic flow_cfg_t base_cfg();
        flow_cfg_t c;
        c.phase = 2'd0; c.burst = 1'b0; c.mode = 1'b0; c.vref = 1'b0; c.data = 16'h0000;
        for (int s = 0; s < 4; s++) begin
            c.pre_busy[s] = 2'd0;
            c.busy_len[s] = 6'd1;
            c.resp_dly[s] = 5'd3;
            c.junk[s]     = 2'd0;
        end
        c.pat_len = 8'd5; c.abort_pat = 1'b0; c.rst_in_result = 1'b0;
        return c;
    endfunction

    // Whole test from IDLE; expected behaviour follows the handshake rules directly.
    task automatic run_flow(input flow_cfg_t c);
        logic [3:0]  code;
        logic [15:0] exp_bus;
        exp_bus = 16'(32'(c.mode) * 16 + 32'(c.burst) * 8 + 32'(c.phase) * 2);
        i_clock_phase = c.phase; i_burst_count = c.burst; i_comparison_mode = c.mode;
        i_datavref_or_valvref = c.vref; i_SB_Busy = 1'b0; i_pattern_finished = 1'b0;
        clear_rx();
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(4'(2 * i + 1));
        i_tx_d2c_pt_en = 1'b1;
        step();
        exp_result = 16'h0000;
        for (int s = 0; s < 4; s++) begin
            code = exp_q.pop_front();
            chk_o("req_entry", 1'b1, code, s == 0, 2'b00, 1'b0, 1'b0, 1'b0);
            if (s == 0) chk16("tx_data_bus", o_tx_data_bus, exp_bus);
            chk16("result_at_req", o_comparison_result, exp_result);
            for (int p = 0; p < int'(c.pre_busy[s]); p++) begin
                step();
                chk_o("req_no_busy", 1'b1, code, s == 0, 2'b00, 1'b0, 1'b0, 1'b0);
            end
            i_SB_Busy = 1'b1;
            for (int b = 0; b < int'(c.busy_len[s]); b++) begin
                step();
                chk_o("req_busy_hold", 1'b1, code, s == 0, 2'b00, 1'b0, 1'b0, 1'b0);
            end
            i_SB_Busy = 1'b0;
            step();
            if (int'(c.resp_dly[s]) >= TO) begin
                for (int k = 0; k < TO; k++) begin
                    chk_o("wait_before_timeout", 1'b0, 4'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
                    drive_junk(c.junk[s], k, code + 4'd1);
                    step();
                end
                clear_rx();
                chk_o("timeout_err", 1'b0, 4'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
                repeat (3) step();
                chk_o("timeout_err_hold", 1'b0, 4'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
                i_tx_d2c_pt_en = 1'b0;
                step();
                quiet("timeout_err_clear");
                return;
            end
            for (int k = 0; k < int'(c.resp_dly[s]); k++) begin
                chk_o("wait", 1'b0, 4'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
                chk16("result_in_wait", o_comparison_result, exp_result);
                drive_junk(c.junk[s], k, code + 4'd1);
                step();
            end
            if (c.rst_in_result && s == 2) begin
                clear_rx();
                i_rst = 1'b1;
                step();
                i_rst = 1'b0;
                i_tx_d2c_pt_en = 1'b0;
                quiet("reset_mid_wait");
                chk16("reset_bus", o_tx_data_bus, 16'h0000);
                chk16("reset_result", o_comparison_result, 16'h0000);
                exp_result = 16'h0000;
                repeat (5) step();
                quiet("reset_no_restart");
                return;
            end
            i_rx_msg_valid   = 1'b1;
            i_decoded_SB_msg = code + 4'd1;
            i_rx_data_bus    = (s == 2) ? c.data : 16'($urandom);
            step();
            clear_rx();
            if (s == 2) exp_result = c.data;
            if (s == 1) begin
                chk_o("pat_clr", 1'b0, 4'd0, 1'b0, 2'b01, c.vref, 1'b0, 1'b0);
                step();
                for (int p = 0; p < int'(c.pat_len); p++) begin
                    chk_o("pat_run", 1'b0, 4'd0, 1'b0, 2'b10, c.vref, 1'b0, 1'b0);
                    if (c.abort_pat && p == int'(c.pat_len) / 2) begin
                        i_tx_d2c_pt_en = 1'b0;
                        step();
                        quiet("abort_idle");
                        chk16("abort_result", o_comparison_result, exp_result);
                        repeat (5) step();
                        quiet("abort_no_result_req");
                        return;
                    end
                    step();
                end
                chk_o("pat_run_last", 1'b0, 4'd0, 1'b0, 2'b10, c.vref, 1'b0, 1'b0);
                i_pattern_finished = 1'b1;
                step();
                i_pattern_finished = 1'b0;
            end
        end
        chk_o("done", 1'b0, 4'd0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        chk16("result_done", o_comparison_result, exp_result);
        repeat (2) step();
        chk_o("done_hold", 1'b0, 4'd0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        i_tx_d2c_pt_en = 1'b0;
        step();
        quiet("done_clear");
        chk16("result_held_idle", o_comparison_result, exp_result);
    endtask

    initial begin
        vec_t      vt[7];
        flow_cfg_t c;

        vt[0] = '{2'd0, 1'b0, 1'b0, 16'h0000};
        vt[1] = '{2'd1, 1'b0, 1'b0, 16'h0002};
        vt[2] = '{2'd2, 1'b0, 1'b0, 16'h0004};
        vt[3] = '{2'd0, 1'b1, 1'b0, 16'h0008};
        vt[4] = '{2'd0, 1'b0, 1'b1, 16'h0010};
        vt[5] = '{2'd2, 1'b1, 1'b1, 16'h001C};
        vt[6] = '{2'd1, 1'b1, 1'b1, 16'h001A};

        // Reset with enable and busy high: reset must dominate
        i_rst = 1'b1; i_tx_d2c_pt_en = 1'b1; i_datavref_or_valvref = 1'b1;
        i_clock_phase = 2'd2; i_burst_count = 1'b1; i_comparison_mode = 1'b1;
        i_pattern_finished = 1'b1; i_SB_Busy = 1'b1; i_rx_msg_valid = 1'b1;
        i_decoded_SB_msg = 4'd2; i_rx_data_bus = 16'hFFFF;
        repeat (2) step();
        quiet("reset_outputs");
        chk16("reset_tx_bus", o_tx_data_bus, 16'h0000);
        chk16("reset_result", o_comparison_result, 16'h0000);
        i_tx_d2c_pt_en = 1'b0; i_SB_Busy = 1'b0; i_pattern_finished = 1'b0;
        clear_rx();
        i_rst = 1'b0;
        repeat (3) step();
        quiet("idle_without_enable");

        // Start-request parameter encoding table
        for (int i = 0; i < 7; i++) begin
            i_clock_phase = vt[i].phase; i_burst_count = vt[i].burst;
            i_comparison_mode = vt[i].mode;
            i_tx_d2c_pt_en = 1'b1;
            step();
            chk_o("tbl_start_req", 1'b1, 4'd1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
            chk16("tbl_tx_bus", o_tx_data_bus, vt[i].exp_bus);
            i_tx_d2c_pt_en = 1'b0;
            step();
            quiet("tbl_back_idle");
        end

        // Normal flow
        c = base_cfg();
        c.phase = 2'd2; c.burst = 1'b1; c.mode = 1'b1; c.vref = 1'b1;
        c.data = 16'hA5C3; c.pat_len = 8'd100;
        run_flow(c);

        // Wrong response code ignored in WAIT_CLR
        c = base_cfg();
        c.junk[1] = 2'd2; c.data = 16'h1234;
        run_flow(c);

        // Timeout waiting for START_RESP
        c = base_cfg();
        c.resp_dly[0] = 5'd20;
        run_flow(c);

        // Abort during pattern run
        c = base_cfg();
        c.vref = 1'b1; c.pat_len = 8'd10; c.abort_pat = 1'b1;
        run_flow(c);

        // Busy held 50 cycles in END_REQ
        c = base_cfg();
        c.busy_len[3] = 6'd50; c.data = 16'h0F0F;
        run_flow(c);

        // Reset mid WAIT_RESULT
        c = base_cfg();
        c.rst_in_result = 1'b1; c.resp_dly[2] = 5'd4;
        run_flow(c);

        // Randomized flows
        for (int t = 0; t < 40; t++) begin
            c = base_cfg();
            c.phase = 2'($urandom_range(0, 2));
            c.burst = 1'($urandom_range(0, 1));
            c.mode  = 1'($urandom_range(0, 1));
            c.vref  = 1'($urandom_range(0, 1));
            c.data  = 16'($urandom);
            for (int s = 0; s < 4; s++) begin
                c.pre_busy[s] = 2'($urandom_range(0, 3));
                c.busy_len[s] = 6'($urandom_range(1, 6));
                c.resp_dly[s] = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(16, 20))
                                                             : 5'($urandom_range(0, 15));
                c.junk[s]     = 2'($urandom_range(0, 1));
            end
            c.pat_len       = 8'($urandom_range(1, 20));
            c.abort_pat     = ($urandom_range(0, 7) == 0);
            c.rst_in_result = ($urandom_range(0, 7) == 0);
            run_flow(c);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
